// File: rtl/i2c_master_byte_engine.sv
`timescale 1ns/1ps
// Single-byte I2C master: START, {addr,rw}, ACK, one data byte, ACK/NACK, STOP; one scl_tick per SCL half-period.
// Define I2C_CLK_STRETCH_EN to let a slave holding SCL low (scl_i=0) stall the high-phase action.
module i2c_master_byte_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_tick,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       scl_o,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_STOP
  } state_e;

  state_e     state_q, state_d;
  logic       phase_q, phase_d;   // 0: next tick is the low half of a slot, 1: the high half
  logic [2:0] bit_q, bit_d;
  logic [1:0] stop_q, stop_d;
  logic [7:0] abyte_q, abyte_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       high_ok;
  logic       tx_drive;
  logic       tx_bit;

`ifdef I2C_CLK_STRETCH_EN
  assign high_ok = scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign high_ok      = 1'b1;
`endif

  assign tx_drive = (state_q == S_ADDR) || (state_q == S_WR_DATA);
  assign tx_bit   = (state_q == S_ADDR) ? abyte_q[bit_q] : wbyte_q[bit_q];

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    abyte_d   = abyte_q;
    wbyte_d   = wbyte_q;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          abyte_d   = {addr, rw};
          wbyte_d   = wdata;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (scl_tick) begin
          sda_oe_d = 1'b1;
          bit_d    = 3'd7;
          phase_d  = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK: begin
        if (scl_tick && !phase_q) begin
          scl_d    = 1'b0;
          sda_oe_d = tx_drive ? ~tx_bit : 1'b0;
          phase_d  = 1'b1;
        end else if (scl_tick && phase_q && high_ok) begin
          scl_d   = 1'b1;
          phase_d = 1'b0;
          stop_d  = 2'd0;
          case (state_q)
            S_ADDR: begin
              if (bit_q == 3'd0) state_d = S_ADDR_ACK;
              else               bit_d   = bit_q - 3'd1;
            end
            S_ADDR_ACK: begin
              bit_d = 3'd7;
              if (sda_i) begin
                ack_err_d = 1'b1;
                state_d   = S_STOP;
              end else begin
                state_d = abyte_q[0] ? S_RD_DATA : S_WR_DATA;
              end
            end
            S_WR_DATA: begin
              if (bit_q == 3'd0) state_d = S_WR_ACK;
              else               bit_d   = bit_q - 3'd1;
            end
            S_WR_ACK: begin
              if (sda_i) ack_err_d = 1'b1;
              state_d = S_STOP;
            end
            S_RD_DATA: begin
              rdata_d = {rdata_q[6:0], sda_i};
              if (bit_q == 3'd0) state_d = S_RD_ACK;
              else               bit_d   = bit_q - 3'd1;
            end
            S_RD_ACK: state_d = S_STOP;
            default: ;
          endcase
        end
      end
      S_STOP: begin
        if (scl_tick) begin
          case (stop_q)
            2'd0: begin
              scl_d    = 1'b0;
              sda_oe_d = 1'b1;
              stop_d   = 2'd1;
            end
            2'd1: begin
              scl_d  = 1'b1;
              stop_d = 2'd2;
            end
            default: begin
              sda_oe_d = 1'b0;
              stop_d   = 2'd0;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      bit_q     <= 3'd7;
      stop_q    <= 2'd0;
      abyte_q   <= 8'h00;
      wbyte_q   <= 8'h00;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      abyte_q   <= abyte_d;
      wbyte_q   <= wbyte_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign scl_o   = scl_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_byte_engine.sv
`timescale 1ns/1ps
// Bench for i2c_master_byte_engine: a slave model answers on SDA, bytes seen on the wire are
// compared against a scoreboard queue, and per-transaction results come from a vector table.
module tb_i2c_master_byte_engine;

  logic       clk = 1'b0;
  logic       rst, scl_tick, start, rw, scl_i;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       scl_o, sda_oe, sda_i, busy, done, ack_err;
  logic       slave_pull = 1'b0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and slave.
  assign sda_i = ~(sda_oe | slave_pull);

  i2c_master_byte_engine dut (
    .clk(clk), .rst(rst), .scl_tick(scl_tick), .start(start), .addr(addr), .rw(rw),
    .wdata(wdata), .scl_o(scl_o), .scl_i(scl_i), .sda_oe(sda_oe), .sda_i(sda_i),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata)
  );

`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 3;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       ack_addr;
    logic       ack_data;
    logic [7:0] rd_byte;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_ticks;
  } vec_t;

  vec_t       vecs[6];
  vec_t       vs;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       cfg_rw = 1'b0, cfg_ack_addr = 1'b0, cfg_ack_data = 1'b0;
  logic [7:0] cfg_rd_byte = 8'h00;
  int         tick_n, stall_from, stall_len;
  bit         seen_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wire monitor and slave model, evaluated away from the active edge.
  int         rise_cnt = 0;
  bit         active = 1'b0;
  bit         prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] shift = 8'h00;
  always @(negedge clk) begin
    logic       line;
    logic [7:0] exp_b;
    line = ~(sda_oe | slave_pull);
    if (rst) begin
      active     = 1'b0;
      slave_pull = 1'b0;
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
    end else begin
      if (prev_scl && scl_o && prev_sda && !line) begin
        active   = 1'b1;
        rise_cnt = 0;
      end else if (prev_scl && scl_o && !prev_sda && line) begin
        active = 1'b0;
      end else if (active && !prev_scl && scl_o) begin
        if (rise_cnt != 8) shift = {shift[6:0], line};
        if (rise_cnt == 7 || rise_cnt == 16) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got byte 0x%0h, expected none", shift);
          end else begin
            exp_b = exp_q.pop_front();
            if (rise_cnt == 7) check("addr_byte", 32'(shift), 32'(exp_b));
            else               check("data_byte", 32'(shift), 32'(exp_b));
          end
        end
        if (rise_cnt == 17 && cfg_rw) check("master_nack_released", 32'(line), 32'd1);
        rise_cnt++;
      end else if (active && prev_scl && !scl_o) begin
        if (rise_cnt == 8)
          slave_pull = cfg_ack_addr;
        else if (rise_cnt >= 9 && rise_cnt <= 16 && cfg_rw && cfg_ack_addr)
          slave_pull = ~cfg_rd_byte[16 - rise_cnt];
        else if (rise_cnt == 17 && !cfg_rw && cfg_ack_addr)
          slave_pull = cfg_ack_data;
        else
          slave_pull = 1'b0;
      end
      prev_scl = scl_o;
      prev_sda = ~(sda_oe | slave_pull);
    end
  end

  // One scl_tick, then either return in the done cycle or idle two cycles.
  task automatic do_tick();
    scl_i    = !(stall_len > 0 && tick_n + 1 >= stall_from && tick_n + 1 < stall_from + stall_len);
    scl_tick = 1'b1;
    @(posedge clk); #1;
    scl_tick = 1'b0;
    tick_n++;
    if (done) begin
      seen_done = 1'b1;
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_done(input int budget);
    while (!seen_done && tick_n < budget) do_tick();
  endtask

  task automatic start_txn(input vec_t v, input bit with_tick);
    cfg_rw       = v.rw;
    cfg_ack_addr = v.ack_addr;
    cfg_ack_data = v.ack_data;
    cfg_rd_byte  = v.rd_byte;
    exp_q.push_back({v.addr, v.rw});
    if (v.ack_addr) exp_q.push_back(v.rw ? v.rd_byte : v.wdata);
    addr     = v.addr;
    rw       = v.rw;
    wdata    = v.wdata;
    start    = 1'b1;
    scl_tick = with_tick;
    scl_i    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    scl_tick = 1'b0;
    check("busy_on_accept", 32'(busy), 32'd1);
    check("ack_err_cleared", 32'(ack_err), 32'd0);
    tick_n    = 0;
    seen_done = 1'b0;
  endtask

  task automatic finish_checks(input vec_t v);
    check("done_seen", 32'(seen_done), 32'd1);
    check("tick_count", 32'(tick_n), 32'(v.exp_ticks));
    check("busy_at_done", 32'(busy), 32'd0);
    check("ack_err", 32'(ack_err), 32'(v.exp_err));
    check("line_idle_scl", 32'(scl_o), 32'd1);
    check("line_idle_sda", 32'(sda_oe), 32'd0);
    if (v.rw) check("rdata", 32'(rdata), 32'(v.exp_rdata));
  endtask

  task automatic run_vec(input vec_t v, input bit with_tick, input bit chain);
    start_txn(v, with_tick);
    run_to_done(100);
    finish_checks(v);
    if (!chain) begin
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; scl_tick = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0; scl_i = 1'b1;
    stall_from = 0; stall_len = 0; tick_n = 0; seen_done = 1'b0;

    vecs[0] = '{addr:7'h50, rw:1'b0, wdata:8'hA5, ack_addr:1'b1, ack_data:1'b1, rd_byte:8'h00,
                exp_err:1'b0, exp_rdata:8'h00, exp_ticks:40};
    vecs[1] = '{addr:7'h22, rw:1'b0, wdata:8'h00, ack_addr:1'b0, ack_data:1'b0, rd_byte:8'h00,
                exp_err:1'b1, exp_rdata:8'h00, exp_ticks:22};
    vecs[2] = '{addr:7'h50, rw:1'b1, wdata:8'h00, ack_addr:1'b1, ack_data:1'b0, rd_byte:8'h3C,
                exp_err:1'b0, exp_rdata:8'h3C, exp_ticks:40};
    vecs[3] = '{addr:7'h7F, rw:1'b0, wdata:8'h00, ack_addr:1'b1, ack_data:1'b0, rd_byte:8'h00,
                exp_err:1'b1, exp_rdata:8'h00, exp_ticks:40};
    vecs[4] = '{addr:7'h00, rw:1'b1, wdata:8'hFF, ack_addr:1'b1, ack_data:1'b0, rd_byte:8'h81,
                exp_err:1'b0, exp_rdata:8'h81, exp_ticks:40};
    vecs[5] = '{addr:7'h2A, rw:1'b0, wdata:8'hFF, ack_addr:1'b1, ack_data:1'b1, rd_byte:8'h00,
                exp_err:1'b0, exp_rdata:8'h00, exp_ticks:40};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_scl_o", 32'(scl_o), 32'd1);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, 1'b0);

    // Back-to-back: start in the done cycle, with a tick in the accept cycle that must be ignored.
    run_vec(vecs[0], 1'b0, 1'b1);
    run_vec(vecs[2], 1'b1, 1'b0);

    // Start pulse mid-transaction is ignored; the original address and data go out.
    start_txn(vecs[0], 1'b0);
    repeat (10) do_tick();
    addr = 7'h11; rw = 1'b1; wdata = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_during_ignored_start", 32'(busy), 32'd1);
    run_to_done(100);
    finish_checks(vecs[0]);
    @(posedge clk); #1;

    // Reset in WR_DATA: lines released at once, no STOP and no done.
    start_txn(vecs[0], 1'b0);
    repeat (24) do_tick();
    check("no_done_before_rst", 32'(seen_done), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_scl_o", 32'(scl_o), 32'd1);
    check("midrst_sda_oe", 32'(sda_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    tick_n = 0;
    repeat (45) do_tick();
    check("no_done_after_rst", 32'(seen_done), 32'd0);

    // SCL held low by the slave on the high tick of address bit 4 (ticks 9..11).
    vs = '{addr:7'h50, rw:1'b0, wdata:8'h5A, ack_addr:1'b1, ack_data:1'b1, rd_byte:8'h00,
           exp_err:1'b0, exp_rdata:8'h00, exp_ticks:40 + STRETCH_EXTRA};
    stall_from = 9;
    stall_len  = 3;
    run_vec(vs, 1'b0, 1'b0);
    stall_len  = 0;

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_engine.md
# i2c_master_byte_engine

Single-byte I2C master transaction engine that consumes the `scl_tick` strobe from the I2C clock divider and produces the SCL/SDA line controls. On each accepted request it issues START, the 7-bit address plus R/W, samples the slave ACK, then transfers one data byte and issues STOP. It sits between the divider and the open-drain pad cells. Each `scl_tick` advances the bus by one SCL half-period.

## Interface
- No parameters: the address is fixed at 7 bits and data at 8 bits per I2C; the SCL rate is set entirely by the upstream divider.
- `clk`  in  1  system clock; the same clock that drives the divider.
- `rst`  in  1  synchronous reset, active-high.
- `scl_tick`  in  1  one-cycle strobe from the divider, one per SCL half-period.
- `start`  in  1  request strobe; accepted only in IDLE.
- `addr`  in  7  slave address; latched on accept.
- `rw`  in  1  0 = write, 1 = read; latched on accept.
- `wdata`  in  8  write byte; latched on accept.
- `scl_o`  out  1  SCL level: 1 = released, 0 = drive low.
- `scl_i`  in  1  sensed SCL pad level; used only with clock stretching enabled.
- `sda_oe`  out  1  1 = drive SDA low, 0 = release.
- `sda_i`  in  1  sensed SDA pad level.
- `busy`  out  1  high from the accept cycle until `done`.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_err`  out  1  slave NACKed the address or write data; valid from `done` until the next accept.
- `rdata`  out  8  read byte; valid from `done` until the next accept.

## Operation
- **States:** IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP.
- **Reset values:** `scl_o`=1, `sda_oe`=0, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0x00, state IDLE. All outputs are registered.
- **IDLE:** with `start`=1, latch `{addr,rw}` and `wdata`, set `busy`=1, clear `ack_err`, and go to START. A `scl_tick` in the accept cycle is ignored.
- **START:** on the next tick, set `sda_oe`=1 while `scl_o`=1 (START condition). Go to ADDR with the bit index at 7.
- **Bit slot (two ticks):**
  - Low tick: `scl_o`=0; `sda_oe` = ~bit for driven bits, 0 for released bits.
  - High tick: `scl_o`=1; sample `sda_i`.
  - Bits go MSB first; the address byte is `{addr,rw}`.
- **ADDR_ACK / WR_ACK:** release SDA for one slot. `sda_i`=1 on the high tick is a NACK: set `ack_err`=1 and go to STOP. Otherwise advance to WR_DATA (rw=0), RD_DATA (rw=1) or STOP (after WR_ACK).
- **RD_DATA:** SDA released for 8 slots; shift the sampled bits into `rdata`.
- **RD_ACK:** master NACK; SDA released for one slot.
- **STOP (three ticks):**
  1. `scl_o`=0, `sda_oe`=1.
  2. `scl_o`=1.
  3. `sda_oe`=0.
  - In the cycle after tick 3: `done`=1, `busy`=0, state IDLE.
- **Request handling:** `start` while busy is ignored. `start` in the cycle after `done` is accepted normally.
- **Reset mid-transaction:** the block returns to its reset values on the next edge. No STOP is generated and no `done` is pulsed.

## Timing
- **Tick counts:**
  - Full transaction: 40 ticks (START 1 + ADDR 16 + ACK 2 + DATA 16 + ACK 2 + STOP 3).
  - Address NACK: 22 ticks (START 1 + ADDR 16 + ACK 2 + STOP 3).
- **Output update:** line outputs change in the cycle after the tick that causes them.
- **`done` latency:** `done` asserts one cycle after the last STOP tick.
- **Absolute duration:** with a 50 MHz clock and a 100 kHz SCL (tick every 250 cycles), a full transaction takes about 10 000 cycles.

## Configuration
- **`I2C_CLK_STRETCH_EN` defined:** on a high tick, if `scl_i`=0 the FSM holds its state and outputs and ignores further ticks. The first tick seen with `scl_i`=1 performs the deferred high-phase action (sample and advance).
- **`I2C_CLK_STRETCH_EN` undefined:** `scl_i` is ignored and the high-tick action always proceeds; the port remains present.

## Test plan
- **Write with ACK:** `start`, addr=0x50, rw=0, wdata=0xA5; slave model ACKs both bytes. SDA carries 0xA0 then 0xA5; `done` asserts after 40 ticks with `ack_err`=0.
- **Address NACK:** addr=0x22, slave releases SDA during the ACK slot. STOP follows and `done` asserts after 22 ticks with `ack_err`=1.
- **Read:** addr=0x50, rw=1, slave returns 0x3C. At `done`, `rdata`=0x3C and SDA was released during the 9th data slot (master NACK).
- **Ignored start:** pulse `start` with addr=0x11 mid-transaction. It is ignored and the original address 0x50 completes unchanged.
- **Reset mid-transfer:** assert `rst` for 1 cycle during WR_DATA. Next cycle shows `scl_o`=1, `sda_oe`=0, `busy`=0, and no `done` pulse.
- **Clock stretch:** with `I2C_CLK_STRETCH_EN`, hold `scl_i`=0 for 3 ticks on address bit 4. The FSM stalls, then resumes, and the transaction completes with correct data.
